// File: rtl/addac_pkg.sv
// Shared types and default sizing for the addac result collector.
package addac_pkg;

  typedef enum logic {IDLE, SHIFT} collect_state_t;

  localparam int unsigned ADDAC_WORD_W = 8;

endpackage

// File: rtl/addac_outbuf.sv
// One-entry valid/ready holding register; a load that cannot be accepted
// is dropped and flagged with a single-cycle overrun pulse.
module addac_outbuf #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic can_load_c;

  // Room exists when empty or when the held entry leaves this cycle.
  assign can_load_c = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (can_load_c) begin
          data  <= din;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/addac_collect.sv
// Collects the addac serial sum stream LSB-first into parallel words tagged
// with the final carry, presented through a one-entry valid/ready buffer.
module addac_collect
  import addac_pkg::*;
#(
  parameter int unsigned WIDTH = ADDAC_WORD_W,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             cout_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             carry_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned SH_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  collect_state_t   state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [SH_W-1:0]  shreg, shreg_nxt;
  logic             frame_err_nxt;
  logic             load_c;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH:0]   buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      shreg     <= shreg_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next-state, bit capture and word completion.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    shreg_nxt     = shreg;
    frame_err_nxt = 1'b0;
    load_c        = 1'b0;
    word_c        = {s_in, shreg};
    if (bit_valid) begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            shreg_nxt    = '0;
            shreg_nxt[0] = s_in;
            count_nxt    = CNT_W'(1);
            state_nxt    = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            // Restart discards the partial word; this bit becomes bit 0.
            shreg_nxt     = '0;
            shreg_nxt[0]  = s_in;
            count_nxt     = CNT_W'(1);
            frame_err_nxt = 1'b1;
          end else if (count == LAST) begin
            load_c    = 1'b1;
            shreg_nxt = '0;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            shreg_nxt[count] = s_in;
            count_nxt        = count + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  addac_outbuf #(
    .WIDTH (WIDTH + 1)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .din     ({cout_in, word_c}),
    .ready   (word_ready),
    .data    (buf_data),
    .valid   (word_valid),
    .overrun (overrun)
  );

  assign word_out  = buf_data[WIDTH-1:0];
  assign carry_out = buf_data[WIDTH];

endmodule
